// File: rtl/srff_ctrl_pkg.sv
// Shared opcode and FSM state encodings for the SR flip-flop bank controller.
package srff_ctrl_pkg;

    // Opcodes 6 and 7 are deliberately left unnamed; they decode as illegal.
    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_SET    = 3'd1,
        OP_CLR    = 3'd2,
        OP_TOGGLE = 3'd3,
        OP_LOAD   = 3'd4,
        OP_BURST  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        BURST = 2'd2
    } state_e;

    localparam logic [2:0] OP_FIRST_ILLEGAL = 3'd6;

endpackage

// File: rtl/srff_bank_ctrl_sr_cell.sv
// Single SR flip-flop: hold on 00, set on 10, clear on 01; 11 must never be driven.
module sr_cell (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q
);

    // Storage element with synchronous reset; flags any forbidden 11 drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            assert (!(s && r));
            if (s)
                q <= 1'b1;
            else if (r)
                q <= 1'b0;
        end
    end

endmodule

// File: rtl/srff_bank_ctrl.sv
// Command-driven sequencer for a bank of SR flip-flops: set/clear/load/toggle/burst.
module srff_bank_ctrl
    import srff_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             err_illegal
);

    state_e           state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             done_set;
    logic             err_set;

    // Next-state and handshake decode; a zero-count burst degenerates to a one-cycle APPLY.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        done_set  = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_op == OP_BURST && cmd_count != '0)
                        state_d = BURST;
                    else
                        state_d = APPLY;
                end
            end
            APPLY: begin
                busy     = 1'b1;
                state_d  = IDLE;
                done_set = 1'b1;
                err_set  = (op_q >= OP_FIRST_ILLEGAL);
            end
            BURST: begin
                busy = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = IDLE;
                    done_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state: FSM, burst down-counter, done pulse and sticky illegal flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            state_q     <= state_d;
            done        <= done_set;
            err_illegal <= err_illegal | err_set;
            if (accept)
                cnt_q <= cmd_count;
            else if (state_q == BURST && cnt_q != '0)
                cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Command fields captured on acceptance; only consulted while busy, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= cmd_op;
            mask_q <= cmd_mask;
            data_q <= cmd_data;
        end
    end

    // s/r drive; every branch makes s and r disjoint per bit, so 11 never reaches a cell.
    always_comb begin
        s_out = '0;
        r_out = '0;
        if (state_q == APPLY) begin
            case (op_q)
                OP_SET: begin
                    s_out = mask_q;
                end
                OP_CLR: begin
                    r_out = mask_q;
                end
                OP_LOAD: begin
                    s_out = mask_q & data_q;
                    r_out = mask_q & ~data_q;
                end
                OP_TOGGLE: begin
                    s_out = mask_q & ~q;
                    r_out = mask_q & q;
                end
                default: begin
                    s_out = '0;
                    r_out = '0;
                end
            endcase
        end else if (state_q == BURST) begin
            s_out = mask_q & ~q;
            r_out = mask_q & q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            sr_cell u_cell (
                .clk (clk),
                .rst (rst),
                .s   (s_out[gi]),
                .r   (r_out[gi]),
                .q   (q[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_srff_bank_ctrl.sv
// Directed bench for srff_bank_ctrl with hand-computed expectations.
module tb_srff_bank_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_mask;
    logic [3:0] cmd_data;
    logic [3:0] cmd_count;
    logic [3:0] s_out;
    logic [3:0] r_out;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       err_illegal;

    int errors = 0;
    int checks = 0;

    srff_bank_ctrl #(.WIDTH(4), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_mask    (cmd_mask),
        .cmd_data    (cmd_data),
        .cmd_count   (cmd_count),
        .s_out       (s_out),
        .r_out       (r_out),
        .q           (q),
        .busy        (busy),
        .done        (done),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and check the s/r disjointness invariant just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("s_and_r_zero", {28'd0, s_out & r_out}, 32'd0);
    endtask

    // Present a command in IDLE, let it be accepted at the next edge, then withdraw it.
    task automatic issue(input logic [2:0] op, input logic [3:0] mask,
                         input logic [3:0] data, input logic [3:0] count);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mask  = mask;
        cmd_data  = data;
        cmd_count = count;
        chk("ready_before_accept", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_mask  = 4'd0;
        cmd_data  = 4'd0;
        cmd_count = 4'd0;
        #1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_q", {28'd0, q}, 32'h0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err_illegal}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_s", {28'd0, s_out}, 32'h0);
        chk("rst_r", {28'd0, r_out}, 32'h0);

        // SET mask=0101
        issue(3'd1, 4'b0101, 4'b0000, 4'd0);
        chk("set_ready_apply", {31'd0, cmd_ready}, 32'd0);
        chk("set_busy_apply", {31'd0, busy}, 32'd1);
        chk("set_s_apply", {28'd0, s_out}, 32'h5);
        chk("set_r_apply", {28'd0, r_out}, 32'h0);
        chk("set_done_apply", {31'd0, done}, 32'd0);
        tick();
        chk("set_q", {28'd0, q}, 32'h5);
        chk("set_done", {31'd0, done}, 32'd1);
        chk("set_ready_after", {31'd0, cmd_ready}, 32'd1);
        tick();
        chk("set_done_once", {31'd0, done}, 32'd0);

        // LOAD mask=1111 data=1010
        issue(3'd4, 4'b1111, 4'b1010, 4'd0);
        chk("load_s", {28'd0, s_out}, 32'hA);
        chk("load_r", {28'd0, r_out}, 32'h5);
        tick();
        chk("load_q", {28'd0, q}, 32'hA);
        chk("load_done", {31'd0, done}, 32'd1);

        // TOGGLE mask=0011 issued in the done cycle
        issue(3'd3, 4'b0011, 4'b0000, 4'd0);
        chk("tog_s", {28'd0, s_out}, 32'h1);
        chk("tog_r", {28'd0, r_out}, 32'h2);
        tick();
        chk("tog_q", {28'd0, q}, 32'h9);
        chk("tog_done", {31'd0, done}, 32'd1);

        // Back-to-back SET mask=1000: bit 3 already set
        issue(3'd1, 4'b1000, 4'b0000, 4'd0);
        chk("b2b_ready_apply", {31'd0, cmd_ready}, 32'd0);
        tick();
        chk("b2b_q", {28'd0, q}, 32'h9);
        chk("b2b_done", {31'd0, done}, 32'd1);

        // Clear everything, then BURST mask=0001 count=5
        issue(3'd2, 4'b1111, 4'b0000, 4'd0);
        tick();
        chk("clr_q", {28'd0, q}, 32'h0);
        issue(3'd5, 4'b0001, 4'b0000, 4'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("burst_busy_%0d", i), {31'd0, busy}, 32'd1);
            chk($sformatf("burst_nodone_%0d", i), {31'd0, done}, 32'd0);
            tick();
            chk($sformatf("burst_q_%0d", i), {28'd0, q}, (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        chk("burst_busy_end", {31'd0, busy}, 32'd0);
        chk("burst_done", {31'd0, done}, 32'd1);
        tick();
        chk("burst_done_once", {31'd0, done}, 32'd0);

        // BURST count=0 behaves as NOP
        issue(3'd5, 4'b1111, 4'b0000, 4'd0);
        chk("b0_busy", {31'd0, busy}, 32'd1);
        chk("b0_s", {28'd0, s_out}, 32'h0);
        chk("b0_r", {28'd0, r_out}, 32'h0);
        tick();
        chk("b0_done", {31'd0, done}, 32'd1);
        chk("b0_q", {28'd0, q}, 32'h1);
        chk("b0_busy_end", {31'd0, busy}, 32'd0);

        // Illegal opcode 6, then legal CLR keeps the sticky flag
        issue(3'd6, 4'b1111, 4'b0000, 4'd0);
        chk("ill_err_apply", {31'd0, err_illegal}, 32'd0);
        tick();
        chk("ill_q", {28'd0, q}, 32'h1);
        chk("ill_done", {31'd0, done}, 32'd1);
        chk("ill_err", {31'd0, err_illegal}, 32'd1);
        issue(3'd2, 4'b1111, 4'b0000, 4'd0);
        tick();
        chk("clr2_q", {28'd0, q}, 32'h0);
        chk("clr2_err", {31'd0, err_illegal}, 32'd1);

        // BURST mask=1111 count=10 aborted by reset after the 3rd toggle
        issue(3'd5, 4'b1111, 4'b0000, 4'd10);
        tick();
        chk("abort_q1", {28'd0, q}, 32'hF);
        tick();
        chk("abort_q2", {28'd0, q}, 32'h0);
        tick();
        chk("abort_q3", {28'd0, q}, 32'hF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_q", {28'd0, q}, 32'h0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_err", {31'd0, err_illegal}, 32'd0);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("abort_done_later", {31'd0, done}, 32'd0);
        chk("abort_q_hold", {28'd0, q}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
